// File: rtl/prio_enc_queue.sv
// Registered priority encoder with a pending set and a valid/ready output register.
// Define PRIO_RR_EN for round-robin selection. The default build uses fixed priority, highest index wins.
module prio_enc_queue #(
   parameter  int N_REQ = 8,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_i,
   input  logic             flush_i,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   input  logic             out_ready,
   output logic [IDX_W:0]   pend_cnt,
   output logic             merge_o
);

   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] clr_mask;
   logic [N_REQ-1:0] pending_next;
   logic [IDX_W-1:0] sel;
   logic [IDX_W:0]   cnt_next;
   logic             issue;
   logic             merge_next;

   assign cand  = pending | req_i;
   assign issue = (|cand) && (!out_valid || out_ready) && !flush_i;

`ifdef PRIO_RR_EN
   logic [IDX_W-1:0] ptr;

   // Walk downward from ptr with wrap-around; the first set candidate wins.
   always_comb begin
      int   k;
      logic found;
      sel   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         k = int'(ptr) - i;
         if (k < 0) k = k + N_REQ;
         if (!found && cand[IDX_W'(k)]) begin
            found = 1'b1;
            sel   = IDX_W'(k);
         end
      end
   end

   // Pointer moves just below the winner so the winner drops to lowest priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= IDX_W'(N_REQ - 1);
      else if (issue)
         ptr <= (sel == '0) ? IDX_W'(N_REQ - 1) : sel - 1'b1;
   end
`else
   // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (cand[IDX_W'(i)]) sel = IDX_W'(i);
      end
   end
`endif

   assign clr_mask     = issue ? (N_REQ'(1) << sel) : '0;
   assign pending_next = cand & ~clr_mask;
   assign merge_next   = |(req_i & pending & ~clr_mask);

   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cnt_next = cnt_next + (IDX_W+1)'(pending_next[IDX_W'(i)]);
      end
   end

   // Flush clears everything but out_idx, which keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         pend_cnt  <= '0;
         merge_o   <= 1'b0;
      end else if (flush_i) begin
         pending   <= '0;
         out_valid <= 1'b0;
         pend_cnt  <= '0;
         merge_o   <= 1'b0;
      end else begin
         pending  <= pending_next;
         pend_cnt <= cnt_next;
         merge_o  <= merge_next;
         if (issue) begin
            out_valid <= 1'b1;
            out_idx   <= sel;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_enc_queue.sv
// Self-checking bench for prio_enc_queue (N_REQ=8): directed vectors plus a per-cycle model compare.
// Compile with PRIO_RR_EN defined to check round-robin mode.
module tb_prio_enc_queue;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] req_i = '0;
   logic         flush_i = 1'b0;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [2:0]   out_idx;
   logic [3:0]   pend_cnt;
   logic         merge_o;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   bit [N-1:0]   m_pend = '0;
   bit           m_valid = 1'b0;
   int           m_idx = 0;
   int           m_cnt = 0;
   bit           m_merge = 1'b0;
`ifdef PRIO_RR_EN
   int           m_ptr = N - 1;
`endif

   prio_enc_queue #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .flush_i   (flush_i),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_ready (out_ready),
      .pend_cnt  (pend_cnt),
      .merge_o   (merge_o)
   );

   always #5 clk = ~clk;

   function automatic int choose(bit [N-1:0] c);
`ifdef PRIO_RR_EN
      for (int j = 0; j < N; j++) begin
         int k;
         k = (m_ptr - j + N) % N;
         if (c[k]) return k;
      end
`else
      for (int k = N - 1; k >= 0; k--) begin
         if (c[k]) return k;
      end
`endif
      return 0;
   endfunction

   // Behavioural model of the queue, advanced at every clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = '0; m_valid = 0; m_idx = 0; m_cnt = 0; m_merge = 0;
`ifdef PRIO_RR_EN
         m_ptr = N - 1;
`endif
      end else if (flush_i) begin
         m_pend = '0; m_valid = 0; m_cnt = 0; m_merge = 0;
      end else begin
         bit [N-1:0] c;
         int pick;
         c = m_pend | req_i;
         if (c != 0 && (!m_valid || out_ready)) begin
            pick = choose(c);
            c[pick] = 1'b0;
            m_merge = ((req_i & m_pend & c) != 0);
            m_valid = 1;
            m_idx = pick;
`ifdef PRIO_RR_EN
            m_ptr = (pick == 0) ? N - 1 : pick - 1;
`endif
         end else begin
            m_merge = ((req_i & m_pend) != 0);
            if (m_valid && out_ready) m_valid = 0;
         end
         m_pend = c;
         m_cnt = $countones(m_pend);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (out_valid !== m_valid || int'(out_idx) != m_idx || int'(pend_cnt) != m_cnt
             || merge_o !== m_merge) begin
            failures++;
            $display("[TB] FAIL model_cmp t=%0t actual v=%b idx=%0d cnt=%0d merge=%b required v=%b idx=%0d cnt=%0d merge=%b",
                     $time, out_valid, out_idx, pend_cnt, merge_o, m_valid, m_idx, m_cnt, m_merge);
         end
      end
   end

   task automatic check_val(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic check_output(input string name, input int v, input int idx, input int cnt, input int mrg);
      check_val({name, "_valid"}, int'(out_valid), v);
      check_val({name, "_idx"}, int'(out_idx), idx);
      check_val({name, "_cnt"}, int'(pend_cnt), cnt);
      check_val({name, "_merge"}, int'(merge_o), mrg);
   endtask

   task automatic apply_stimulus(input logic [N-1:0] req, input logic rdy, input logic flush);
      req_i = req;
      out_ready = rdy;
      flush_i = flush;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int exp5[4];
`ifdef PRIO_RR_EN
      exp5 = '{7, 0, 7, 0};
`else
      exp5 = '{7, 7, 7, 7};
`endif
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset", 0, 0, 0, 0);
      rst_n = 1'b1;

      // Two simultaneous requests drain highest-first.
      apply_stimulus(8'h06, 1, 0); check_output("t1_c1", 1, 2, 1, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t1_c2", 1, 1, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t1_c3", 0, 1, 0, 0);

      // Backpressure holds the output while a new request waits.
      apply_stimulus(8'h80, 0, 0); check_output("t2_c1", 1, 7, 0, 0);
      apply_stimulus(8'h01, 0, 0); check_output("t2_c2", 1, 7, 1, 0);
      apply_stimulus(8'h00, 0, 0); check_output("t2_c3", 1, 7, 1, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t2_c4", 1, 0, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t2_c5", 0, 0, 0, 0);

      // Repeated request on a pending bit merges into one issue.
      apply_stimulus(8'h20, 0, 0); check_output("t3_c1", 1, 5, 0, 0);
      apply_stimulus(8'h04, 0, 0); check_output("t3_c2", 1, 5, 1, 0);
      apply_stimulus(8'h04, 0, 0); check_output("t3_c3", 1, 5, 1, 1);
      apply_stimulus(8'h00, 0, 0); check_output("t3_c4", 1, 5, 1, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t3_c5", 1, 2, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t3_c6", 0, 2, 0, 0);

      // Flush beats a same-cycle request and accept.
      apply_stimulus(8'h01, 0, 0); check_output("t4_c1", 1, 0, 0, 0);
      apply_stimulus(8'h3C, 0, 0); check_output("t4_c2", 1, 0, 4, 0);
      apply_stimulus(8'hFF, 1, 1); check_output("t4_flush", 0, 0, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t4_c4", 0, 0, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t4_c5", 0, 0, 0, 0);

      // Held request on both ends of the vector.
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(8'h81, 1, 0);
         check_val($sformatf("t5_idx%0d", i), int'(out_idx), exp5[i]);
         check_val($sformatf("t5_cnt%0d", i), int'(pend_cnt), 1);
      end
      repeat (3) apply_stimulus(8'h00, 1, 0);
      check_output("t5_drain", 0, int'(out_idx), 0, 0);

      // Asynchronous reset in the middle of a stalled transfer.
      apply_stimulus(8'h01, 0, 0); check_output("t6_c1", 1, 0, 0, 0);
      apply_stimulus(8'h0E, 0, 0); check_output("t6_c2", 1, 0, 3, 0);
      req_i = '0;
      #3 rst_n = 1'b0;
      #1 check_output("t6_async", 0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      apply_stimulus(8'h00, 1, 0); check_output("t6_idle1", 0, 0, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t6_idle2", 0, 0, 0, 0);
      apply_stimulus(8'h10, 1, 0); check_output("t6_newreq", 1, 4, 0, 0);
      apply_stimulus(8'h00, 1, 0); check_output("t6_done", 0, 4, 0, 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
